// File: rtl/reg_copy_engine_pkg.sv
// Shared command and state encodings for the register copy engine.
// Latency: none (type and constant definitions only).
// Backpressure: not applicable.
package reg_copy_engine_pkg;

  typedef enum logic [1:0] {
    OP_COPY = 2'd0,
    OP_FILL = 2'd1,
    OP_SUM  = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/reg_copy_engine.sv
// Register bank engine: COPY / FILL / SUM over a wrapping window of up to 8 registers.
// Latency: done pulses count+1 cycles after start is sampled (1 cycle for count==0 or reserved op).
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
module reg_copy_engine
  import reg_copy_engine_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   count,
  input  logic [DW-1:0] fill_data,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          bank_we,
  output logic [AW-1:0] bank_write_addr,
  output logic [DW-1:0] bank_write_data,
  output logic [AW-1:0] bank_read_addr,
  input  logic [DW-1:0] bank_read_data
);

  state_e        state_q;
  state_e        state_d;
  op_e           op_q;
  logic [AW-1:0] src_ptr;
  logic [AW-1:0] dst_ptr;
  logic [AW:0]   remaining;
  logic [DW-1:0] fill_q;
  logic [DW-1:0] acc;
  logic [DW-1:0] sum_next;
  logic          accept;
  logic          no_work;
  logic          last_elem;

  assign accept    = (state_q == ST_IDLE) && start;
  assign no_work   = (count == '0) || (op_e'(op) == OP_RSVD);
  assign last_elem = (remaining == (AW+1)'(1));
  assign sum_next  = acc + bank_read_data;

  // State register; reset aborts any command in flight without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: empty or reserved commands skip straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = no_work ? ST_DONE : ST_RUN;
      ST_RUN:  if (last_elem) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Command latch, pointer walk, accumulator and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_COPY;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      fill_q    <= '0;
      acc       <= '0;
      result    <= '0;
    end else if (accept) begin
      op_q      <= op_e'(op);
      src_ptr   <= src_addr;
      dst_ptr   <= dst_addr;
      remaining <= count;
      fill_q    <= fill_data;
      acc       <= '0;
      // Going straight to DONE: an empty SUM reports its cleared accumulator,
      // a reserved op reports zero, COPY/FILL leave the old result alone.
      if (no_work && ((op_e'(op) == OP_SUM) || (op_e'(op) == OP_RSVD))) result <= '0;
    end else if (state_q == ST_RUN) begin
      // Pointers are AW bits wide so they wrap 7->0 on their own.
      src_ptr   <= src_ptr + AW'(1);
      dst_ptr   <= dst_ptr + AW'(1);
      remaining <= remaining - (AW+1)'(1);
      if (op_q == OP_SUM) begin
        acc <= sum_next;
        // The final element is folded in on the same edge that enters DONE.
        if (last_elem) result <= sum_next;
      end
    end
  end

  // Outputs decode from state so reset clears them without a clock edge.
  always_comb begin
    busy            = (state_q == ST_RUN) || (state_q == ST_DONE);
    done            = (state_q == ST_DONE);
    bank_we         = 1'b0;
    bank_read_addr  = '0;
    bank_write_addr = '0;
    bank_write_data = '0;
    if (state_q == ST_RUN) begin
      bank_read_addr  = src_ptr;
      bank_write_addr = dst_ptr;
      case (op_q)
        OP_COPY: begin
          bank_we         = 1'b1;
          bank_write_data = bank_read_data;
        end
        OP_FILL: begin
          bank_we         = 1'b1;
          bank_write_data = fill_q;
        end
        default: begin
          bank_we         = 1'b0;
          bank_write_data = '0;
        end
      endcase
    end
  end

endmodule
